// File: rtl/intc_arbiter.sv
// intc_arbiter: arbitrates up to eight interrupt sources onto one INT line.
// Sources are synchronised, latched as pending, masked, and the lowest index
// wins. One request is held until the control unit acks it; the source stays
// in service until eoi. No nesting.
// Build option INTC_LEVEL_EN: when defined, a per-line EDGE register selects
// edge or level detection; otherwise every line is edge-triggered.

module intc_arbiter #(
   parameter int unsigned NUM_IRQ = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_IRQ-1:0]  irq_i,
   input  logic                int_ack_i,
   input  logic                eoi_i,
   input  logic [1:0]          reg_sel_i,
   input  logic                reg_we_i,
   input  logic [31:0]         reg_wdata_i,
   output logic [31:0]         reg_rdata_o,
   output logic                int_o,
   output logic [3:0]          vector_o
);

   localparam logic [3:0] VEC_NONE = 4'hF;
   localparam logic [1:0] SEL_MASK = 2'd0;
   localparam logic [1:0] SEL_EDGE = 2'd1;
   localparam logic [1:0] SEL_PEND = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } state_e;

   state_e               state_q;
   logic                 int_q;
   logic [3:0]           vector_q;
   logic [NUM_IRQ-1:0]   s1_q, s2_q, s3_q;
   logic [NUM_IRQ-1:0]   mask_q;
   logic [NUM_IRQ-1:0]   pend_q, pend_d;
   logic [NUM_IRQ-1:0]   edge_lines_c;
   logic [NUM_IRQ-1:0]   rise_c;
   logic [NUM_IRQ-1:0]   req_c;
   logic [3:0]           win_c;
   logic                 ack_take_c;
   logic                 w1c_c;
   logic                 unused_wdata_c;

   // Write data above the implemented lines is intentionally dropped.
   assign unused_wdata_c = ^reg_wdata_i[31:NUM_IRQ];

`ifdef INTC_LEVEL_EN
   logic [NUM_IRQ-1:0]   edge_q;

   // Per-line trigger type, 1 = edge, 0 = level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         edge_q <= '1;
      end else if (reg_we_i && (reg_sel_i == SEL_EDGE)) begin
         edge_q <= reg_wdata_i[NUM_IRQ-1:0];
      end
   end

   assign edge_lines_c = edge_q;
`else
   assign edge_lines_c = '1;
`endif

   // Two-flop synchroniser plus one history flop for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= '0;
         s2_q <= '0;
         s3_q <= '0;
      end else begin
         s1_q <= irq_i;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign rise_c     = s2_q & ~s3_q;
   assign req_c      = pend_q & mask_q;
   assign w1c_c      = reg_we_i && (reg_sel_i == SEL_PEND);
   assign ack_take_c = (state_q == ST_REQ) && int_ack_i && (req_c != '0);

   // Fixed priority: lowest set index of the pre-write request vector.
   always_comb begin
      win_c = VEC_NONE;
      for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
         if (req_c[i]) begin
            win_c = 4'(i);
         end
      end
   end

   // Pending update: clears first, then a same-cycle set event wins.
   always_comb begin
      pend_d = pend_q;
      for (int i = 0; i < int'(NUM_IRQ); i++) begin
         if (edge_lines_c[i]) begin
            if (w1c_c && reg_wdata_i[i]) begin
               pend_d[i] = 1'b0;
            end
            if (ack_take_c && (win_c == 4'(i))) begin
               pend_d[i] = 1'b0;
            end
            if (rise_c[i]) begin
               pend_d[i] = 1'b1;
            end
         end else begin
            pend_d[i] = s2_q[i];
         end
      end
   end

   // Pending and mask registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q <= '0;
         mask_q <= '0;
      end else begin
         pend_q <= pend_d;
         if (reg_we_i && (reg_sel_i == SEL_MASK)) begin
            mask_q <= reg_wdata_i[NUM_IRQ-1:0];
         end
      end
   end

   // Request / service state machine with registered int and vector.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         int_q    <= 1'b0;
         vector_q <= VEC_NONE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_c != '0) begin
                  state_q <= ST_REQ;
                  int_q   <= 1'b1;
               end
            end
            ST_REQ: begin
               if (int_ack_i) begin
                  state_q  <= ST_SERVICE;
                  int_q    <= 1'b0;
                  vector_q <= (req_c != '0) ? win_c : VEC_NONE;
               end else if (req_c == '0) begin
                  state_q <= ST_IDLE;
                  int_q   <= 1'b0;
               end
            end
            ST_SERVICE: begin
               int_q <= 1'b0;
               if (eoi_i) begin
                  state_q  <= ST_IDLE;
                  vector_q <= VEC_NONE;
               end
            end
            default: begin
               state_q  <= ST_IDLE;
               int_q    <= 1'b0;
               vector_q <= VEC_NONE;
            end
         endcase
      end
   end

   // Combinational register read port.
   always_comb begin
      reg_rdata_o = '0;
      case (reg_sel_i)
         SEL_MASK: reg_rdata_o = 32'(mask_q);
         SEL_EDGE: reg_rdata_o = 32'(edge_lines_c);
         SEL_PEND: reg_rdata_o = 32'(pend_q);
         default:  reg_rdata_o = {26'b0, (state_q == ST_SERVICE),
                                  (state_q == ST_REQ), vector_q};
      endcase
   end

   assign int_o    = int_q;
   assign vector_o = vector_q;

endmodule

// File: tb/tb_intc_arbiter.sv
// Self-checking bench for intc_arbiter: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.

module tb_intc_arbiter;

   localparam int unsigned N    = 8;
   localparam int unsigned ALL  = 32'hFF;
   localparam int unsigned M_IDLE = 0;
   localparam int unsigned M_REQ  = 1;
   localparam int unsigned M_SVC  = 2;

   logic        clk;
   logic        rst_n;
   logic [7:0]  irq_i;
   logic        int_ack_i;
   logic        eoi_i;
   logic [1:0]  reg_sel_i;
   logic        reg_we_i;
   logic [31:0] reg_wdata_i;
   logic [31:0] reg_rdata_o;
   logic        int_o;
   logic [3:0]  vector_o;

   int n_checks;
   int n_errors;

   // model state
   int unsigned m_mask, m_edg, m_pend, m_vec, m_mode;
   int unsigned m_sync [3];

   intc_arbiter #(.NUM_IRQ(N)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .irq_i       (irq_i),
      .int_ack_i   (int_ack_i),
      .eoi_i       (eoi_i),
      .reg_sel_i   (reg_sel_i),
      .reg_we_i    (reg_we_i),
      .reg_wdata_i (reg_wdata_i),
      .reg_rdata_o (reg_rdata_o),
      .int_o       (int_o),
      .vector_o    (vector_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_mask = 0;
      m_edg  = ALL;
      m_pend = 0;
      m_vec  = 15;
      m_mode = M_IDLE;
      for (int i = 0; i < 3; i++) m_sync[i] = 0;
   endtask

   function automatic int unsigned m_rdata(input int unsigned sel);
      case (sel)
         0: return m_mask;
         1: return m_edg;
         2: return m_pend;
         default: return ((m_mode == M_SVC) ? 32 : 0) + ((m_mode == M_REQ) ? 16 : 0) + m_vec;
      endcase
   endfunction

   // One clock edge of the reference behaviour, using pre-edge state.
   task automatic m_step(input int unsigned irq, input bit ack, input bit eoi,
                         input bit we, input int unsigned sel, input int unsigned wd);
      int unsigned s2, s3, req, win, p, np;
      bit found;
      s2 = m_sync[1];
      s3 = m_sync[2];
      req = m_pend & m_mask;
      win = 15;
      found = 0;
      for (int i = 0; i < int'(N); i++) begin
         if (!found && ((req >> i) & 1) == 1) begin
            win = i;
            found = 1;
         end
      end
      p = m_pend;
      if (we && sel == 2) p = p & ~wd;
      if (m_mode == M_REQ && ack && req != 0) p = p & ~(32'd1 << win);
      p = p | (s2 & ~s3);
      np = ((p & m_edg) | (s2 & ~m_edg)) & ALL;
      case (m_mode)
         M_IDLE: if (req != 0) m_mode = M_REQ;
         M_REQ: begin
            if (ack) begin
               m_mode = M_SVC;
               m_vec  = (req != 0) ? win : 15;
            end else if (req == 0) begin
               m_mode = M_IDLE;
            end
         end
         default: if (eoi) begin
            m_mode = M_IDLE;
            m_vec  = 15;
         end
      endcase
      if (we && sel == 0) m_mask = wd & ALL;
`ifdef INTC_LEVEL_EN
      if (we && sel == 1) m_edg = wd & ALL;
`endif
      m_pend = np;
      m_sync[2] = m_sync[1];
      m_sync[1] = m_sync[0];
      m_sync[0] = irq & ALL;
   endtask

   // Called just after a falling edge: drive, check read port, clock, check outputs.
   task automatic step(input logic [7:0] irq, input logic ack, input logic eoi,
                       input logic we, input logic [1:0] sel, input logic [31:0] wd);
      irq_i       = irq;
      int_ack_i   = ack;
      eoi_i       = eoi;
      reg_we_i    = we;
      reg_sel_i   = sel;
      reg_wdata_i = wd;
      #1;
      chk("rdata", reg_rdata_o, m_rdata(32'(sel)));
      @(posedge clk);
      m_step(32'(irq), ack, eoi, we, 32'(sel), wd);
      @(negedge clk);
      chk("int_o", 32'(int_o), (m_mode == M_REQ) ? 32'd1 : 32'd0);
      chk("vector_o", 32'(vector_o), m_vec);
      irq_i = irq;  // hold line level between steps
   endtask

   task automatic idle(input int n, input logic [7:0] irq);
      for (int i = 0; i < n; i++) step(irq, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
   endtask

   task automatic wr(input logic [1:0] sel, input logic [31:0] wd);
      step(8'h00, 1'b0, 1'b0, 1'b1, sel, wd);
   endtask

   task automatic chk_reg(input string tag, input logic [1:0] sel, input logic [31:0] exp);
      reg_we_i  = 1'b0;
      reg_sel_i = sel;
      #1;
      chk(tag, reg_rdata_o, exp);
   endtask

   initial begin
      logic [7:0] rirq;
      n_checks    = 0;
      n_errors    = 0;
      rst_n       = 1'b0;
      irq_i       = '0;
      int_ack_i   = 1'b0;
      eoi_i       = 1'b0;
      reg_sel_i   = 2'd0;
      reg_we_i    = 1'b0;
      reg_wdata_i = '0;
      m_reset();
      repeat (2) @(negedge clk);

      // reset values
      chk("rst_int", 32'(int_o), 32'd0);
      chk("rst_vec", 32'(vector_o), 32'hF);
      chk_reg("rst_mask", 2'd0, 32'h0);
      chk_reg("rst_edge", 2'd1, 32'hFF);
      chk_reg("rst_pend", 2'd2, 32'h0);
      chk_reg("rst_status", 2'd3, 32'h0F);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // single edge pulse on line 5
      wr(2'd0, 32'hFF);
      step(8'h20, 0, 0, 0, 2'd0, 0);
      idle(2, 8'h00);
      chk("lat_not_yet", 32'(int_o), 32'd0);
      idle(1, 8'h00);
      chk("lat_4", 32'(int_o), 32'd1);
      step(8'h00, 1, 0, 0, 2'd0, 0);
      chk("ack_vec5", 32'(vector_o), 32'd5);
      chk_reg("pend_after_ack5", 2'd2, 32'h00);
      chk_reg("status_svc", 2'd3, 32'h25);
      step(8'h00, 0, 1, 0, 2'd0, 0);
      chk("eoi_vec", 32'(vector_o), 32'hF);

      // lines 6 and 2 together: priority, then the leftover after eoi
      step(8'h44, 0, 0, 0, 2'd0, 0);
      idle(3, 8'h00);
      chk("two_int", 32'(int_o), 32'd1);
      step(8'h00, 1, 0, 0, 2'd0, 0);
      chk("prio_vec2", 32'(vector_o), 32'd2);
      chk_reg("pend_40", 2'd2, 32'h40);
      step(8'h00, 0, 1, 0, 2'd0, 0);
      chk("eoi_int_low", 32'(int_o), 32'd0);
      idle(1, 8'h00);
      chk("reraise", 32'(int_o), 32'd1);
      step(8'h00, 1, 0, 0, 2'd0, 0);
      chk("next_vec6", 32'(vector_o), 32'd6);
      step(8'h00, 0, 1, 0, 2'd0, 0);

      // masked edge stays pending; unmasking raises int
      wr(2'd0, 32'h00);
      step(8'h08, 0, 0, 0, 2'd0, 0);
      idle(3, 8'h00);
      chk_reg("masked_pend", 2'd2, 32'h08);
      chk("masked_int", 32'(int_o), 32'd0);
      wr(2'd0, 32'h08);
      chk("unmask_1", 32'(int_o), 32'd0);
      idle(1, 8'h00);
      chk("unmask_2", 32'(int_o), 32'd1);

      // W1C of the only request, then an ack finds nothing
      wr(2'd2, 32'h08);
      chk("w1c_prewrite_int", 32'(int_o), 32'd1);
      chk_reg("w1c_pend", 2'd2, 32'h00);
      step(8'h00, 1, 0, 0, 2'd0, 0);
      chk("spurious_vec", 32'(vector_o), 32'hF);
      step(8'h00, 0, 1, 0, 2'd0, 0);

      // ack in the same cycle as W1C arbitrates on pre-write state
      step(8'h08, 0, 0, 0, 2'd0, 0);
      idle(3, 8'h00);
      step(8'h00, 1, 0, 1, 2'd2, 32'h08);
      chk("ack_w1c_vec3", 32'(vector_o), 32'd3);
      chk_reg("ack_w1c_pend", 2'd2, 32'h00);
      step(8'h00, 0, 1, 0, 2'd0, 0);

`ifdef INTC_LEVEL_EN
      // level line 0 survives ack and re-raises after eoi
      wr(2'd1, 32'hFE);
      wr(2'd0, 32'h01);
      step(8'h01, 0, 0, 0, 2'd0, 0);
      idle(3, 8'h01);
      chk("lvl_int", 32'(int_o), 32'd1);
      step(8'h01, 1, 0, 0, 2'd0, 0);
      chk("lvl_vec0", 32'(vector_o), 32'd0);
      chk_reg("lvl_pend", 2'd2, 32'h01);
      step(8'h01, 0, 1, 0, 2'd0, 0);
      idle(1, 8'h01);
      chk("lvl_reraise", 32'(int_o), 32'd1);
      step(8'h00, 1, 0, 0, 2'd0, 0);
      step(8'h00, 0, 1, 0, 2'd0, 0);
      idle(5, 8'h00);
      wr(2'd1, 32'hFF);
`else
      wr(2'd1, 32'h00);
      chk_reg("edge_fixed", 2'd1, 32'hFF);
`endif

      // asynchronous reset in the middle of service
      wr(2'd0, 32'hFF);
      step(8'h12, 0, 0, 0, 2'd0, 0);
      idle(4, 8'h00);
      step(8'h00, 1, 0, 0, 2'd0, 0);
      chk("pre_rst_vec1", 32'(vector_o), 32'd1);
      chk_reg("pre_rst_pend", 2'd2, 32'h10);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_int", 32'(int_o), 32'd0);
      chk("arst_vec", 32'(vector_o), 32'hF);
      chk_reg("arst_mask", 2'd0, 32'h0);
      chk_reg("arst_pend", 2'd2, 32'h0);
      m_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // random traffic
      rirq = '0;
      for (int c = 0; c < 3000; c++) begin
         logic a, e, w;
         logic [1:0] s;
         logic [31:0] d;
         rirq = rirq ^ 8'($urandom & $urandom & $urandom);
         a = ($urandom_range(0, 2) == 0);
         e = ($urandom_range(0, 3) == 0);
         w = ($urandom_range(0, 5) == 0);
         s = 2'($urandom_range(0, 3));
         d = $urandom;
         step(rirq, a, e, w, s, d);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
